// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input vector of a small gate and checks its output against a truth table
module gate_truth_checker #(
  parameter int N_IN = 2,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 4'b1000,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [(1<<N_IN)-1:0]   fail_vec
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FIN} state_t;
  state_t                 state_q;
  logic [N_IN-1:0]        vec_q, dut_in_q;
  logic [SW-1:0]          settle_q;
  logic                   busy_q, done_q, pass_q;
  logic [N_IN:0]          err_q, err_d;
  logic [(1<<N_IN)-1:0]   fail_q;
  logic                   mis;
  // X/Z on the gate output must count as a mismatch
  assign mis = dut_out !== EXP_TT[vec_q];
  assign err_d = err_q + {{N_IN{1'b0}}, mis};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      dut_in_q <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          vec_q    <= '0;
          dut_in_q <= '0;
          settle_q <= '0;
          err_q    <= '0;
          fail_q   <= '0;
          pass_q   <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (settle_q == SW'(SETTLE_CYC - 1)) state_q <= SAMPLE;
          else settle_q <= settle_q + SW'(1);
        end
        SAMPLE: begin
          err_q <= err_d;
          if (mis) fail_q[vec_q] <= 1'b1;
          if (vec_q == '1) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= err_d == '0;
          end else begin
            vec_q    <= vec_q + N_IN'(1);
            dut_in_q <= vec_q + N_IN'(1);
            settle_q <= '0;
            state_q  <= SETTLE;
          end
        end
        FIN: begin
          done_q   <= 1'b0;
          dut_in_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: drives two checker instances (2-input and 3-input) against modelled gates
module tb_gate_truth_checker;
  logic clk = 1'b0, rst = 1'b1, start2 = 1'b0, start3 = 1'b0;
  logic [1:0] dut_in2;
  logic [2:0] dut_in3;
  logic busy2, done2, pass2, busy3, done3, pass3;
  logic [2:0] err2;
  logic [3:0] err3, fail2;
  logic [7:0] fail3;
  logic [3:0] gt2 = 4'b1000;
  logic [7:0] gt3 = 8'h80;
  logic sel = 1'b0;
  logic [7:0] o_in, o_fail, o_err;
  logic o_busy, o_done, o_pass;
  int n = 0, fails = 0;
  always #5 clk = ~clk;
  gate_truth_checker u2 (.clk(clk), .rst(rst), .start(start2), .dut_in(dut_in2), .dut_out(gt2[dut_in2]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2));
  gate_truth_checker #(.N_IN(3), .EXP_TT(8'h80), .SETTLE_CYC(1)) u3 (.clk(clk), .rst(rst), .start(start3),
    .dut_in(dut_in3), .dut_out(gt3[dut_in3]), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_vec(fail3));
  assign o_in   = sel ? {5'd0, dut_in3} : {6'd0, dut_in2};
  assign o_fail = sel ? fail3 : {4'd0, fail2};
  assign o_err  = sel ? {4'd0, err3} : {5'd0, err2};
  assign o_busy = sel ? busy3 : busy2;
  assign o_done = sel ? done3 : done2;
  assign o_pass = sel ? pass3 : pass2;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // Expected results come straight from the truth tables: a vector fails wherever gate and table disagree
  task automatic run(input bit w, input logic [7:0] gt, input bit repulse);
    int nv, s, len, e;
    logic [7:0] fv;
    nv = w ? 8 : 4;
    s = w ? 1 : 2;
    len = 1 + nv * (s + 1);
    fv = (gt ^ (w ? 8'h80 : 8'h08)) & 8'((1 << nv) - 1);
    e = $countones(fv);
    sel = w;
    if (w) gt3 = gt; else gt2 = gt[3:0];
    @(negedge clk);
    if (w) start3 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    start3 = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (repulse) start2 = (c == 5 || c == 12);
      if (c < len) begin
        chk("busy", 32'(o_busy), 1);
        chk("done_early", 32'(o_done), 0);
        chk("dut_in", 32'(o_in), 32'((c - 1) / (s + 1)));
      end else begin
        chk("done", 32'(o_done), 1);
        chk("busy_fin", 32'(o_busy), 0);
        chk("dut_in_fin", 32'(o_in), 32'(nv - 1));
        chk("pass", 32'(o_pass), 32'(e == 0));
        chk("err_count", 32'(o_err), 32'(e));
        chk("fail_vec", 32'(o_fail), 32'(fv));
      end
      @(posedge clk); #1;
    end
    start2 = 1'b0;
    chk("done_pulse", 32'(o_done), 0);
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_dut_in", 32'(o_in), 0);
    chk("hold_err", 32'(o_err), 32'(e));
    chk("hold_fail", 32'(o_fail), 32'(fv));
    chk("hold_pass", 32'(o_pass), 32'(e == 0));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs2", {dut_in2, busy2, done2, pass2, err2, fail2}, 0);
    chk("rst_outs3", {dut_in3, busy3, done3, pass3, err3, fail3}, 0);
    rst = 1'b0;
    run(0, 8'h08, 0);
    run(0, 8'h00, 0);
    run(0, 8'h0E, 0);
    run(0, 8'h08, 1);
    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outs", {dut_in2, busy2, done2, pass2, err2, fail2}, 0);
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      chk("midrst_nodone", 32'(done2), 0);
      @(posedge clk); #1;
    end
    run(0, 8'h08, 0);
    run(1, 8'h80, 0);
    run(1, 8'h7F, 0);
    for (int k = 0; k < 6; k++) begin
      run(0, 8'($urandom_range(15)), 0);
      run(1, 8'($urandom), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
